pe_mem_req_arbiter: RTL

- Shares one single-ported PE local memory bank between NUM_REQ requesters: load/store unit read, load/store unit write, DMA read and DMA write.
- Round-robin arbitration with burst locking: a granted requester holds the bank until its burst ends.
- Tracks in-flight reads through a fixed-latency pipeline and routes read data back to the issuing requester.
- Sits between the load/store-to-memory-controller and DMA-to-memory interfaces and the memory macro.

---
 rtl/pe_mem_arb_pkg.sv | 24 ++
 rtl/pe_rr_pick.sv | 30 +++
 rtl/pe_mem_req_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pe_mem_arb_pkg.sv
// rtl/pe_mem_arb_pkg.sv - shared types for the PE local-memory request arbiter
package pe_mem_arb_pkg;

    localparam int LS_RD_ID  = 0;
    localparam int LS_WR_ID  = 1;
    localparam int DMA_RD_ID = 2;
    localparam int DMA_WR_ID = 3;

    localparam int PE_NUM_REQ = DMA_WR_ID + 1;
    localparam int REQ_ID_W   = $clog2(PE_NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_trk_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pe_rr_pick.sv
// rtl/pe_rr_pick.sv - round-robin picker: first valid index at or above ptr, wrapping
module pe_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_oh_o,
    output logic [ID_W-1:0] gnt_id_o
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt_oh_o = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = ID_W'((int'(ptr_i) + i) % N);
            if (!found && valid_i[idx]) begin
                found         = 1'b1;
                gnt_id_o      = idx;
                gnt_oh_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_mem_req_arbiter.sv
// rtl/pe_mem_req_arbiter.sv - burst-locking round-robin arbiter for one PE memory bank
module pe_mem_req_arbiter
    import pe_mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = PE_NUM_REQ,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_wr,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic                       mem_ready,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e         state_q, state_d;
    req_id_t            rr_ptr_q, rr_ptr_d;
    req_id_t            grant_q, grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    rd_trk_t            rd_pipe_q [RD_LAT];
    rd_trk_t            rd_push, rd_tail;
    logic [NUM_REQ-1:0] pick_oh;
    req_id_t            pick_id;
    logic               own_valid, own_wr, own_last, accept, burst_end;

    pe_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (REQ_ID_W)
    ) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_oh_o (pick_oh),
        .gnt_id_o (pick_id)
    );

    assign own_valid = req_valid[grant_q];
    assign own_wr    = req_wr[grant_q];
    assign own_last  = req_last[grant_q];
    assign accept    = (state_q == ST_BUSY) && own_valid && mem_ready;
    // Forced release on the MAX_BURST-th beat keeps one owner from starving the rest.
    assign burst_end = own_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick_oh) begin
                    state_d    = ST_BUSY;
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (burst_end) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = req_id_t'((int'(grant_q) + 1) % NUM_REQ);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_BUSY) begin
            req_ready[grant_q] = mem_ready;
            mem_wr             = own_wr;
            mem_addr           = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
            mem_wdata          = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
        end
    end

    assign mem_en = accept;

    // Read ids ride alongside the memory latency so the tail lines up with mem_rdata.
    assign rd_push = '{valid: accept & ~own_wr, id: grant_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rd_pipe_q[0] <= rd_push;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign rd_tail   = rd_pipe_q[RD_LAT-1];
    assign rsp_valid = rd_tail.valid ? (NUM_REQ'(1) << rd_tail.id) : '0;
    assign rsp_data  = rd_tail.valid ? mem_rdata : '0;
    assign grant_id  = grant_q;
    assign busy      = (state_q == ST_BUSY);

endmodule
